alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/watch_pkg.sv | 33 +++
 rtl/alarm_ctrl_if.sv | 51 +++++
 rtl/alarm_match.sv | 49 ++++
 rtl/alarm_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the watch alarm slice: alarm state encodings, the BCD
// digit type used for time/alarm digits, default timing parameters and the
// counter widths used by the alarm controller.
// No ports (package).
// -----------------------------------------------------------------------------
package watch_pkg;

    // Alarm controller states; the encoding is visible on state_out, so the
    // values are fixed rather than left to the tool.
    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } alarm_state_t;

    // One BCD digit of a time value.
    typedef logic [3:0] bcd_digit_t;

    // Default ring length, snooze delay and snooze limit.
    localparam int RING_SEC_DEF   = 60;
    localparam int SNOOZE_SEC_DEF = 300;
    localparam int MAX_SNOOZE_DEF = 3;

    // Counter widths sized for the largest legal parameter values
    // (RING_SEC up to 64, SNOOZE_SEC up to 512, MAX_SNOOZE up to 3).
    localparam int RING_CNT_W   = 6;
    localparam int SNZ_CNT_W    = 9;
    localparam int SNOOZE_CNT_W = 2;

endpackage

// File: rtl/alarm_ctrl_if.sv
// -----------------------------------------------------------------------------
// alarm_ctrl_if
// Bundles the alarm controller's functional signals.
//   tick_1hz    : one-cycle pulse per second
//   alarm_on    : alarm enable level
//   stop_btn    : one-cycle debounced stop pulse
//   snooze_btn  : one-cycle debounced snooze pulse
//   hh_t..mm_u  : current time, BCD (hours tens/units, minutes tens/units)
//   ah_t..am_u  : alarm time, BCD
//   buzzer      : registered beep drive
//   ringing     : high in RINGING
//   snoozing    : high in SNOOZE
//   state_out   : current state encoding
// Modports: master drives the inputs and observes the outputs; slave is the
// controller side.
// -----------------------------------------------------------------------------
interface alarm_ctrl_if;
    import watch_pkg::*;

    logic       tick_1hz;
    logic       alarm_on;
    logic       stop_btn;
    logic       snooze_btn;
    bcd_digit_t hh_t;
    bcd_digit_t hh_u;
    bcd_digit_t mm_t;
    bcd_digit_t mm_u;
    bcd_digit_t ah_t;
    bcd_digit_t ah_u;
    bcd_digit_t am_t;
    bcd_digit_t am_u;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] state_out;

    modport master (
        output tick_1hz, alarm_on, stop_btn, snooze_btn,
        output hh_t, hh_u, mm_t, mm_u,
        output ah_t, ah_u, am_t, am_u,
        input  buzzer, ringing, snoozing, state_out
    );

    modport slave (
        input  tick_1hz, alarm_on, stop_btn, snooze_btn,
        input  hh_t, hh_u, mm_t, mm_u,
        input  ah_t, ah_u, am_t, am_u,
        output buzzer, ringing, snoozing, state_out
    );

endinterface

// File: rtl/alarm_match.sv
// -----------------------------------------------------------------------------
// alarm_match
// Compares the current time with the alarm time digit by digit and produces a
// single-cycle pulse on the cycle where the two first become equal.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   hh_t_i..mm_u_i    : current time digits
//   ah_t_i..am_u_i    : alarm time digits
//   match_rise_o      : high for one cycle when the times start to match
// -----------------------------------------------------------------------------
module alarm_match
    import watch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  bcd_digit_t hh_t_i,
    input  bcd_digit_t hh_u_i,
    input  bcd_digit_t mm_t_i,
    input  bcd_digit_t mm_u_i,
    input  bcd_digit_t ah_t_i,
    input  bcd_digit_t ah_u_i,
    input  bcd_digit_t am_t_i,
    input  bcd_digit_t am_u_i,
    output logic       match_rise_o
);

    logic match_d;
    logic match_q;

    // The times match when all four digits agree.
    assign match_d = (hh_t_i == ah_t_i) && (hh_u_i == ah_u_i) &&
                     (mm_t_i == am_t_i) && (mm_u_i == am_u_i);

    // Remember last cycle's match so that a match held for the whole minute
    // produces exactly one rising edge. Reset clears it, so a match that is
    // already present when reset releases shows up as a rise one cycle later;
    // the controller ignores that rise because it is still in OFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    // Rising edge of the match condition.
    assign match_rise_o = match_d & ~match_q;

endmodule

// File: rtl/alarm_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ctrl
// Alarm clock controller: arms when enabled, rings when the current time
// reaches the alarm time, beeps the buzzer once per second for RING_SEC
// seconds, and optionally supports up to MAX_SNOOZE snoozes of SNOOZE_SEC
// seconds each.
// Parameters:
//   RING_SEC   : ring duration in seconds before auto-stop (2..64)
//   SNOOZE_SEC : snooze delay in seconds (2..512)
//   MAX_SNOOZE : maximum snoozes per alarm event (1..3)
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alarm_ctrl_if.slave (inputs, time digits, status outputs)
// Configuration macro:
//   ALARM_SNOOZE_EN : when defined, the snooze button and SNOOZE state are
//                     built; otherwise snooze_btn is ignored, SNOOZE is never
//                     entered and snoozing is tied low.
// -----------------------------------------------------------------------------
module alarm_ctrl
    import watch_pkg::*;
#(
    parameter int RING_SEC   = RING_SEC_DEF,
    parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
    parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    alarm_ctrl_if.slave  bus
);

    // Terminal counts expressed at counter width so comparisons stay exact.
    localparam logic [RING_CNT_W-1:0] RING_LAST = RING_CNT_W'(RING_SEC - 1);

    alarm_state_t          state_q;
    alarm_state_t          state_d;
    logic                  buzzer_q;
    logic                  buzzer_d;
    logic [RING_CNT_W-1:0] ring_cnt_q;
    logic [RING_CNT_W-1:0] ring_cnt_d;
    logic                  match_rise;

`ifdef ALARM_SNOOZE_EN
    localparam logic [SNZ_CNT_W-1:0]    SNZ_LAST   = SNZ_CNT_W'(SNOOZE_SEC - 1);
    localparam logic [SNOOZE_CNT_W-1:0] SNOOZE_LIM = SNOOZE_CNT_W'(MAX_SNOOZE);

    logic [SNZ_CNT_W-1:0]    snz_cnt_q;
    logic [SNZ_CNT_W-1:0]    snz_cnt_d;
    logic [SNOOZE_CNT_W-1:0] snooze_cnt_q;
    logic [SNOOZE_CNT_W-1:0] snooze_cnt_d;
`else
    // Snooze hardware is absent; the button and snooze parameters are
    // deliberately left without a consumer.
    logic unused_snooze;
    assign unused_snooze = bus.snooze_btn ^ (SNOOZE_SEC > MAX_SNOOZE);
`endif

    // Time comparison and rising-edge detection live in their own block.
    alarm_match u_match (
        .clk          (clk),
        .rst          (rst),
        .hh_t_i       (bus.hh_t),
        .hh_u_i       (bus.hh_u),
        .mm_t_i       (bus.mm_t),
        .mm_u_i       (bus.mm_u),
        .ah_t_i       (bus.ah_t),
        .ah_u_i       (bus.ah_u),
        .am_t_i       (bus.am_t),
        .am_u_i       (bus.am_u),
        .match_rise_o (match_rise)
    );

    // State register together with the buzzer and all counters. Reset is
    // asynchronous so a ring or snooze in progress is silenced immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OFF;
            buzzer_q     <= 1'b0;
            ring_cnt_q   <= '0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q    <= '0;
            snooze_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            buzzer_q     <= buzzer_d;
            ring_cnt_q   <= ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q    <= snz_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
`endif
        end
    end

    // Next-state logic. Priority is fixed: a low alarm_on beats everything,
    // then stop, then snooze, then the per-second timeout. Every exit from a
    // state clears the counter that state owns, so no counter ever wraps.
    // snooze_cnt survives the SNOOZE <-> RINGING loop because it counts
    // snoozes for the whole alarm event; it is cleared on return to ARMED.
    always_comb begin
        state_d      = state_q;
        buzzer_d     = buzzer_q;
        ring_cnt_d   = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d    = snz_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
`endif

        if (!bus.alarm_on) begin
            state_d      = ST_OFF;
            buzzer_d     = 1'b0;
            ring_cnt_d   = '0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_d    = '0;
            snooze_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                // A match edge seen while still OFF is intentionally dropped.
                ST_OFF: begin
                    state_d = ST_ARMED;
                end

                ST_ARMED: begin
                    if (match_rise) begin
                        state_d      = ST_RINGING;
                        buzzer_d     = 1'b1;
                        ring_cnt_d   = '0;
`ifdef ALARM_SNOOZE_EN
                        snz_cnt_d    = '0;
                        snooze_cnt_d = '0;
`endif
                    end
                end

                ST_RINGING: begin
                    if (bus.stop_btn) begin
                        state_d      = ST_ARMED;
                        buzzer_d     = 1'b0;
                        ring_cnt_d   = '0;
`ifdef ALARM_SNOOZE_EN
                        snooze_cnt_d = '0;
                    end else if (bus.snooze_btn && (snooze_cnt_q < SNOOZE_LIM)) begin
                        state_d      = ST_SNOOZE;
                        buzzer_d     = 1'b0;
                        ring_cnt_d   = '0;
                        snz_cnt_d    = '0;
                        snooze_cnt_d = snooze_cnt_q + 1'b1;
`endif
                    end else if (bus.tick_1hz) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_d      = ST_ARMED;
                            buzzer_d     = 1'b0;
                            ring_cnt_d   = '0;
`ifdef ALARM_SNOOZE_EN
                            snooze_cnt_d = '0;
`endif
                        end else begin
                            buzzer_d   = ~buzzer_q;
                            ring_cnt_d = ring_cnt_q + 1'b1;
                        end
                    end
                end

                ST_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                    if (bus.stop_btn) begin
                        state_d      = ST_ARMED;
                        buzzer_d     = 1'b0;
                        snz_cnt_d    = '0;
                        snooze_cnt_d = '0;
                    end else if (bus.tick_1hz) begin
                        if (snz_cnt_q == SNZ_LAST) begin
                            state_d    = ST_RINGING;
                            buzzer_d   = 1'b1;
                            ring_cnt_d = '0;
                            snz_cnt_d  = '0;
                        end else begin
                            snz_cnt_d = snz_cnt_q + 1'b1;
                        end
                    end
`else
                    // Unreachable without snooze support; recover quietly.
                    state_d  = ST_ARMED;
                    buzzer_d = 1'b0;
`endif
                end

                default: begin
                    state_d  = ST_OFF;
                    buzzer_d = 1'b0;
                end
            endcase
        end
    end

    // Status outputs decoded straight from the registered state, so they are
    // glitch-free and line up with the registered buzzer.
    always_comb begin
        bus.buzzer    = buzzer_q;
        bus.ringing   = (state_q == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
        bus.snoozing  = (state_q == ST_SNOOZE);
`else
        bus.snoozing  = 1'b0;
`endif
        bus.state_out = state_q;
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_ctrl
// Directed bench for alarm_ctrl with RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2.
// Alarm is set to 07:30. Inputs change and outputs are sampled 1 ns after
// each rising clock edge. The snooze section follows ALARM_SNOOZE_EN.
// -----------------------------------------------------------------------------
module tb_alarm_ctrl;
    import watch_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alarm_ctrl_if bus ();

    alarm_ctrl #(
        .RING_SEC   (4),
        .SNOOZE_SEC (3),
        .MAX_SNOOZE (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Drive the one-cycle pulses for a single clock, then sample after the edge.
    task automatic applyStimulus(input logic tick, input logic stop, input logic snz);
        bus.tick_1hz   = tick;
        bus.stop_btn   = stop;
        bus.snooze_btn = snz;
        @(posedge clk);
        #1;
        bus.tick_1hz   = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
    endtask

    task automatic setTime(input logic [3:0] ht, input logic [3:0] hu,
                           input logic [3:0] mt, input logic [3:0] mu);
        bus.hh_t = ht;
        bus.hh_u = hu;
        bus.mm_t = mt;
        bus.mm_u = mu;
    endtask

    // Leave the alarm minute and come back so a fresh match edge occurs.
    task automatic rematch();
        setTime(4'd0, 4'd7, 4'd3, 4'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        setTime(4'd0, 4'd7, 4'd3, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0] expState [4];
        logic       expBuz   [4];
        logic [1:0] expSnz   [3];

        checks = 0;
        errors = 0;
        rst            = 1'b1;
        bus.alarm_on   = 1'b0;
        bus.tick_1hz   = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
        bus.ah_t = 4'd0;
        bus.ah_u = 4'd7;
        bus.am_t = 4'd3;
        bus.am_u = 4'd0;
        setTime(4'd0, 4'd7, 4'd2, 4'd9);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_state", 32'(bus.state_out), 32'd0);
        checkOutput("rst_buzzer", 32'(bus.buzzer), 32'd0);
        checkOutput("rst_ringing", 32'(bus.ringing), 32'd0);
        checkOutput("rst_snoozing", 32'(bus.snoozing), 32'd0);
        rst = 1'b0;

        // Enable -> ARMED.
        bus.alarm_on = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("arm_state", 32'(bus.state_out), 32'd1);

        // Basic ring: 07:29 -> 07:30.
        setTime(4'd0, 4'd7, 4'd3, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ring_state", 32'(bus.state_out), 32'd2);
        checkOutput("ring_buzzer", 32'(bus.buzzer), 32'd1);
        checkOutput("ring_ringing", 32'(bus.ringing), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ring_hold_buzzer", 32'(bus.buzzer), 32'd1);
        expState = '{2'd2, 2'd2, 2'd2, 2'd1};
        expBuz   = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("tick%0d_state", i), 32'(bus.state_out), 32'(expState[i]));
            checkOutput($sformatf("tick%0d_buzzer", i), 32'(bus.buzzer), 32'(expBuz[i]));
        end

        // Stop, then no retrigger while the minute is held.
        rematch();
        checkOutput("rering_state", 32'(bus.state_out), 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("stop_state", 32'(bus.state_out), 32'd1);
        checkOutput("stop_buzzer", 32'(bus.buzzer), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("held%0d_state", i), 32'(bus.state_out), 32'd1);
        end
        rematch();
        checkOutput("again_state", 32'(bus.state_out), 32'd2);

`ifdef ALARM_SNOOZE_EN
        // Two snoozes allowed, the third ignored.
        expSnz = '{2'd3, 2'd3, 2'd2};
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("snz%0d_state", s), 32'(bus.state_out), 32'd3);
            checkOutput($sformatf("snz%0d_snoozing", s), 32'(bus.snoozing), 32'd1);
            checkOutput($sformatf("snz%0d_buzzer", s), 32'(bus.buzzer), 32'd0);
            for (int i = 0; i < 3; i++) begin
                applyStimulus(1'b1, 1'b0, 1'b0);
                checkOutput($sformatf("snz%0d_tick%0d_state", s, i),
                            32'(bus.state_out), 32'(expSnz[i]));
            end
            checkOutput($sformatf("snz%0d_back_buzzer", s), 32'(bus.buzzer), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("snz_limit_state", 32'(bus.state_out), 32'd2);
        checkOutput("snz_limit_snoozing", 32'(bus.snoozing), 32'd0);
        checkOutput("snz_limit_buzzer", 32'(bus.buzzer), 32'd1);
`else
        // Snooze button has no effect without snooze support.
        expSnz = '{2'd2, 2'd2, 2'd2};
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("nosnz_state", 32'(bus.state_out), 32'(expSnz[0]));
        checkOutput("nosnz_snoozing", 32'(bus.snoozing), 32'd0);
        checkOutput("nosnz_buzzer", 32'(bus.buzzer), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("nosnz_tick_buzzer", 32'(bus.buzzer), 32'd0);
        checkOutput("nosnz_tick_state", 32'(bus.state_out), 32'(expSnz[1]));
`endif

        // Priority: stop beats snooze.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("prio_stop_state", 32'(bus.state_out), 32'd1);
        checkOutput("prio_stop_snoozing", 32'(bus.snoozing), 32'd0);
        checkOutput("prio_stop_buzzer", 32'(bus.buzzer), 32'd0);

        // Priority: alarm_on low beats stop.
        rematch();
        checkOutput("prio_ring_state", 32'(bus.state_out), 32'd2);
        bus.alarm_on = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("prio_off_state", 32'(bus.state_out), 32'd0);
        checkOutput("prio_off_buzzer", 32'(bus.buzzer), 32'd0);
        bus.alarm_on = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rearm_state", 32'(bus.state_out), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rearm_noring", 32'(bus.state_out), 32'd1);

        // Asynchronous reset in the middle of an alarm event.
        rematch();
        checkOutput("pre_rst_state", 32'(bus.state_out), 32'd2);
`ifdef ALARM_SNOOZE_EN
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pre_rst_snooze", 32'(bus.state_out), 32'd3);
`endif
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_state", 32'(bus.state_out), 32'd0);
        checkOutput("async_rst_buzzer", 32'(bus.buzzer), 32'd0);
        checkOutput("async_rst_ringing", 32'(bus.ringing), 32'd0);
        checkOutput("async_rst_snoozing", 32'(bus.snoozing), 32'd0);

        // Release reset with the time already matching: arm without ringing.
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("post_rst%0d_state", i), 32'(bus.state_out), 32'd1);
            checkOutput($sformatf("post_rst%0d_buzzer", i), 32'(bus.buzzer), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
